// File: rtl/knn_ctrl_if.sv
// CPU-bus control/readout front end for knn_core: drives enable and sample pulses,
// and captures the 2*DATA_W core value into a coherent snapshot read as two words.
module knn_ctrl_if #(
   parameter int DATA_W = 32,
   parameter int ADDR_W = 3
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  valid,
   input  logic [ADDR_W-1:0]     address,
   input  logic [DATA_W-1:0]     wdata,
   input  logic [DATA_W/8-1:0]   wstrb,
   output logic [DATA_W-1:0]     rdata,
   output logic                  ready,
   output logic                  KNN_ENABLE,
   output logic                  KNN_SAMPLE,
   input  logic [2*DATA_W-1:0]   KNN_VALUE
);

   localparam logic [ADDR_W-1:0] A_CTRL   = ADDR_W'(0);
   localparam logic [ADDR_W-1:0] A_SAMPLE = ADDR_W'(1);
   localparam logic [ADDR_W-1:0] A_PERIOD = ADDR_W'(2);
   localparam logic [ADDR_W-1:0] A_LO     = ADDR_W'(3);
   localparam logic [ADDR_W-1:0] A_HI     = ADDR_W'(4);
   localparam logic [ADDR_W-1:0] A_STATUS = ADDR_W'(5);

   typedef enum logic [1:0] {IDLE, PULSE, CAPTURE} state_t;

   state_t              state_reg, state_next;
   logic                pending_reg, pending_next;
   logic                ready_reg;
   logic [DATA_W-1:0]   rdata_reg, rdata_next;
   logic                ctrl_reg;
   logic [DATA_W-1:0]   period_reg, count_reg;
   logic [2*DATA_W-1:0] snap_reg;
   logic                new_reg, overrun_reg;

   logic [DATA_W-1:0]   wmask;
   logic                accept, is_write, wr, rd;
   logic                sw_req, per_req, capture, hi_read, st_read, period_wr;

   genvar gi;
   generate
      for (gi = 0; gi < DATA_W/8; gi++) begin : g_mask
         assign wmask[gi*8 +: 8] = {8{wstrb[gi]}};
      end
   endgenerate

   // The cycle after ready never accepts, giving at most one access per two cycles.
   assign accept    = valid && !ready_reg;
   assign is_write  = |wstrb;
   assign wr        = accept && is_write;
   assign rd        = accept && !is_write;
   assign period_wr = wr && (address == A_PERIOD);
   assign hi_read   = rd && (address == A_HI);
   assign st_read   = rd && (address == A_STATUS);
   assign sw_req    = wr && (address == A_SAMPLE) && wdata[0];
   assign per_req   = ctrl_reg && (period_reg != '0) && (count_reg == period_reg - DATA_W'(1));

   always_comb begin
      state_next   = state_reg;
      pending_next = pending_reg;
      capture      = 1'b0;
      case (state_reg)
         IDLE: begin
            if (sw_req || per_req || pending_reg) begin
               state_next   = PULSE;
               pending_next = 1'b0;
            end
         end
         PULSE: begin
            state_next = CAPTURE;
            if (sw_req || per_req) pending_next = 1'b1;
         end
         CAPTURE: begin
            state_next = IDLE;
            capture    = 1'b1;
            if (sw_req || per_req) pending_next = 1'b1;
         end
         default: state_next = IDLE;
      endcase
   end

   always_comb begin
      rdata_next = '0;
      if (rd) begin
         case (address)
            A_CTRL:   rdata_next[0] = ctrl_reg;
            A_PERIOD: rdata_next    = period_reg;
            A_LO:     rdata_next    = snap_reg[DATA_W-1:0];
            A_HI:     rdata_next    = snap_reg[2*DATA_W-1:DATA_W];
            A_STATUS: rdata_next[2:0] = {state_reg != IDLE, overrun_reg, new_reg};
            default:  rdata_next    = '0;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_reg   <= IDLE;
         pending_reg <= 1'b0;
         ready_reg   <= 1'b0;
         rdata_reg   <= '0;
         ctrl_reg    <= 1'b0;
         period_reg  <= '0;
         count_reg   <= '0;
         snap_reg    <= '0;
         new_reg     <= 1'b0;
         overrun_reg <= 1'b0;
      end else begin
         state_reg   <= state_next;
         pending_reg <= pending_next;
         ready_reg   <= accept;
         rdata_reg   <= rdata_next;

         if (wr && (address == A_CTRL) && wstrb[0]) ctrl_reg <= wdata[0];
         if (period_wr) period_reg <= (period_reg & ~wmask) | (wdata & wmask);

         if (period_wr || !ctrl_reg || (period_reg == '0) || per_req)
            count_reg <= '0;
         else
            count_reg <= count_reg + DATA_W'(1);

         // A HI read in the capture cycle consumes the old value, so it cannot cause an overrun.
         if (capture) begin
            snap_reg <= KNN_VALUE;
            new_reg  <= 1'b1;
            if (new_reg && !hi_read) overrun_reg <= 1'b1;
            else if (st_read)        overrun_reg <= 1'b0;
         end else begin
            if (hi_read) new_reg     <= 1'b0;
            if (st_read) overrun_reg <= 1'b0;
         end
      end
   end

   assign rdata      = rdata_reg;
   assign ready      = ready_reg;
   assign KNN_ENABLE = ctrl_reg;
   assign KNN_SAMPLE = (state_reg == PULSE);

endmodule

// File: tb/tb_knn_ctrl_if.sv
// Self-checking bench for knn_ctrl_if: directed sequence with random core values and
// periods, compared against a register-level reference model of the snapshot/status rules.
module tb_knn_ctrl_if;
   logic        clk = 1'b0;
   logic        rst, valid, ready, KNN_ENABLE, KNN_SAMPLE;
   logic [2:0]  address;
   logic [31:0] wdata, rdata;
   logic [3:0]  wstrb;
   logic [63:0] KNN_VALUE;

   int total = 0;
   int bad   = 0;
   int cyc   = 0;
   int pulses[$];

   logic [63:0] m_snap;
   bit          m_new, m_ovr, m_ctrl;
   logic [31:0] m_period;

   always #5 clk = ~clk;

   knn_ctrl_if dut (
      .clk(clk), .rst(rst), .valid(valid), .address(address), .wdata(wdata),
      .wstrb(wstrb), .rdata(rdata), .ready(ready), .KNN_ENABLE(KNN_ENABLE),
      .KNN_SAMPLE(KNN_SAMPLE), .KNN_VALUE(KNN_VALUE)
   );

   // Records the index of every cycle in which a sample pulse was high.
   always @(posedge clk) begin
      if (KNN_SAMPLE === 1'b1) pulses.push_back(cyc);
      cyc = cyc + 1;
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
      $display("check %s observed=%0h expected=%0h", tag, obs, exp);
   endtask

   task automatic bus(input logic [2:0] a, input logic [31:0] d, input bit w, output logic [31:0] r);
      int n;
      valid = 1'b1; address = a; wdata = d; wstrb = w ? 4'hF : 4'h0;
      n = 0;
      step();
      while (ready !== 1'b1 && n < 10) begin
         step();
         n++;
      end
      check("bus_ready", ready, 1'b1);
      r = rdata;
      valid = 1'b0; wstrb = 4'h0;
   endtask

   task automatic wr(input logic [2:0] a, input logic [31:0] d);
      logic [31:0] dummy;
      bus(a, d, 1'b1, dummy);
   endtask

   task automatic m_capture();
      if (m_new) m_ovr = 1'b1;
      m_new  = 1'b1;
      m_snap = KNN_VALUE;
   endtask

   // coll: the read is accepted in the capture cycle, so it sees pre-capture state.
   task automatic rd_chk(input logic [2:0] a, input string tag, input bit coll);
      logic [31:0] got, exp;
      bus(a, 32'h0, 1'b0, got);
      case (a)
         3'd0: exp = {31'b0, m_ctrl};
         3'd2: exp = m_period;
         3'd3: exp = m_snap[31:0];
         3'd4: begin exp = m_snap[63:32]; m_new = 1'b0; end
         3'd5: begin exp = {29'b0, coll, m_ovr, m_new}; m_ovr = 1'b0; end
         default: exp = 32'h0;
      endcase
      check(tag, got, exp);
      if (coll) m_capture();
   endtask

   task automatic do_sample();
      wr(3'd1, 32'h1);
      check("pulse_on", KNN_SAMPLE, 1'b1);
      step();
      check("pulse_off", KNN_SAMPLE, 1'b0);
      m_capture();
      step();
   endtask

   initial begin
      int p, r0;
      rst = 1'b0; valid = 1'b1; address = 3'd5; wdata = 32'h0; wstrb = 4'h0;
      KNN_VALUE = 64'h0;
      m_snap = 64'h0; m_new = 1'b0; m_ovr = 1'b0; m_ctrl = 1'b0; m_period = 32'h0;

      for (int i = 0; i < 5; i++) begin
         step();
         check("rst_ready", ready, 1'b0);
         check("rst_sample", KNN_SAMPLE, 1'b0);
         check("rst_enable", KNN_ENABLE, 1'b0);
         check("rst_rdata", rdata, 32'h0);
      end
      valid = 1'b0; rst = 1'b1;
      step();
      rd_chk(3'd5, "status_after_rst", 1'b0);

      wr(3'd0, 32'h1); m_ctrl = 1'b1;
      check("enable_on", KNN_ENABLE, 1'b1);
      rd_chk(3'd0, "ctrl_rb", 1'b0);

      for (int i = 0; i < 4; i++) begin
         KNN_VALUE = {$urandom, $urandom};
         do_sample();
         rd_chk(3'd5, "status_new", 1'b0);
         rd_chk(3'd3, "value_lo", 1'b0);
         rd_chk(3'd4, "value_hi", 1'b0);
         rd_chk(3'd5, "status_clr", 1'b0);
      end

      KNN_VALUE = {32'h0, $urandom};
      do_sample();
      rd_chk(3'd3, "coh_lo", 1'b0);
      KNN_VALUE[63:32] = 32'h1;
      rd_chk(3'd4, "coh_hi", 1'b0);

      KNN_VALUE = {$urandom, $urandom};
      do_sample();
      KNN_VALUE = {$urandom, $urandom};
      do_sample();
      rd_chk(3'd5, "status_ovr", 1'b0);
      rd_chk(3'd5, "status_ovr_clr", 1'b0);
      rd_chk(3'd4, "ovr_hi", 1'b0);
      rd_chk(3'd5, "status_idle", 1'b0);

      wr(3'd3, $urandom);
      wr(3'd6, $urandom);
      rd_chk(3'd6, "addr6_zero", 1'b0);
      rd_chk(3'd3, "lo_ro", 1'b0);
      rd_chk(3'd1, "sample_reads0", 1'b0);
      m_period = $urandom | 32'h1000_0000;
      wr(3'd2, m_period);
      rd_chk(3'd2, "period_rb", 1'b0);
      wr(3'd2, 32'h0); m_period = 32'h0;

      // Reads accepted in the capture cycle.
      KNN_VALUE = {$urandom, $urandom};
      wr(3'd1, 32'h1);
      rd_chk(3'd3, "coll_lo_old", 1'b1);
      KNN_VALUE = {$urandom, $urandom};
      wr(3'd1, 32'h1);
      rd_chk(3'd4, "coll_hi_old", 1'b1);
      rd_chk(3'd5, "coll_hi_status", 1'b0);
      KNN_VALUE = {$urandom, $urandom};
      wr(3'd1, 32'h1);
      rd_chk(3'd5, "coll_status", 1'b1);
      rd_chk(3'd5, "coll_status_after", 1'b0);
      rd_chk(3'd4, "coll_hi_final", 1'b0);
      rd_chk(3'd5, "coll_clean", 1'b0);

      // SAMPLE write landing on the period wrap.
      pulses.delete();
      wr(3'd2, 32'd10); m_period = 32'd10; r0 = cyc;
      while (cyc < r0 + 9) step();
      wr(3'd1, 32'h1);
      check("merge_wrap_pulse", KNN_SAMPLE, 1'b1);
      while (cyc < r0 + 16) step();
      wr(3'd2, 32'h0); m_period = 32'h0;
      m_capture();
      check("merge_wrap_count", pulses.size(), 1);
      check("merge_wrap_time", pulses[0], r0 + 10);

      // SAMPLE write during CAPTURE becomes a pending pulse 3 cycles later.
      step(); step();
      pulses.delete();
      wr(3'd1, 32'h1);
      wr(3'd1, 32'h1);
      for (int i = 0; i < 4; i++) step();
      m_capture(); m_capture();
      check("merge_cap_count", pulses.size(), 2);
      check("merge_cap_gap", pulses[1] - pulses[0], 3);
      rd_chk(3'd4, "merge_hi", 1'b0);
      rd_chk(3'd5, "merge_status", 1'b0);

      // Random period: six pulses exactly p cycles apart.
      p = $urandom_range(3, 12);
      pulses.delete();
      wr(3'd2, p); m_period = p; r0 = cyc;
      while (cyc < r0 + 6*p) step();
      wr(3'd2, 32'h0); m_period = 32'h0;
      for (int i = 0; i < 4; i++) step();
      check("per_count", pulses.size(), 6);
      for (int k = 0; k < pulses.size() && k < 6; k++) begin
         check("per_time", pulses[k], r0 + (k+1)*p);
         m_capture();
      end
      rd_chk(3'd5, "per_status", 1'b0);
      rd_chk(3'd4, "per_hi", 1'b0);
      rd_chk(3'd5, "per_status_clr", 1'b0);

      // PERIOD=1: continuous requests, pulses every 3 cycles.
      pulses.delete();
      wr(3'd2, 32'h1); m_period = 32'h1; r0 = cyc;
      while (cyc < r0 + 12) step();
      wr(3'd2, 32'h0); m_period = 32'h0;
      for (int i = 0; i < 4; i++) step();
      check("p1_count", pulses.size(), 5);
      for (int k = 0; k < pulses.size() && k < 5; k++) begin
         check("p1_time", pulses[k], r0 + 1 + 3*k);
         m_capture();
      end
      rd_chk(3'd3, "p1_lo", 1'b0);
      rd_chk(3'd5, "p1_status", 1'b0);

      // Reset in the PULSE cycle aborts the capture.
      KNN_VALUE = {$urandom, $urandom} | 64'h1;
      wr(3'd1, 32'h1);
      check("rst_mid_pulse", KNN_SAMPLE, 1'b1);
      rst = 1'b0;
      step();
      rst = 1'b1;
      m_snap = 64'h0; m_new = 1'b0; m_ovr = 1'b0; m_ctrl = 1'b0;
      check("rst_mid_sample", KNN_SAMPLE, 1'b0);
      check("rst_mid_enable", KNN_ENABLE, 1'b0);
      step(); step();
      rd_chk(3'd3, "rst_mid_lo", 1'b0);
      rd_chk(3'd4, "rst_mid_hi", 1'b0);
      rd_chk(3'd5, "rst_mid_status", 1'b0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end
endmodule

// File: doc/knn_ctrl_if.md
# knn_ctrl_if

Software-side control/readout front end for `knn_core`, sitting between the native CPU bus (valid/ready) and the core's `KNN_ENABLE`/`KNN_SAMPLE`/`KNN_VALUE` pins. It is the initiator and reader for the core's sample protocol. It drives enable and one-cycle sample pulses, either on software request or periodically. It captures the 2*DATA_W-wide `KNN_VALUE` into a coherent snapshot that the CPU reads as two DATA_W words, and it flags new and overrun status.

## Interface
- `DATA_W`, 32, bus data width; `KNN_VALUE` is 2*DATA_W.
- `ADDR_W`, 3, word address width.

- `clk`  in  1  clock, all logic on rising edge.
- `rst`  in  1  synchronous, active-low reset.
- `valid`  in  1  bus request.
- `address`  in  ADDR_W  word address.
- `wdata`  in  DATA_W  write data.
- `wstrb`  in  DATA_W/8  write strobes; any bit set = write, all zero = read.
- `rdata`  out  DATA_W  read data, valid while `ready`=1.
- `ready`  out  1  one-cycle request acknowledge.
- `KNN_ENABLE`  out  1  core count enable.
- `KNN_SAMPLE`  out  1  one-cycle sample pulse to core.
- `KNN_VALUE`  in  2*DATA_W  core sampled value.

## Operation
- Register map:
  - 0 CTRL: RW, bit0 drives `KNN_ENABLE`.
  - 1 SAMPLE: write with wdata[0]=1 raises a sample request; reads as 0.
  - 2 PERIOD: RW, DATA_W bits; 0 = periodic sampling off.
  - 3 VALUE_LO: R, snapshot[DATA_W-1:0].
  - 4 VALUE_HI: R, snapshot[2*DATA_W-1:DATA_W]; a read clears NEW.
  - 5 STATUS: R, bit0 NEW, bit1 OVERRUN (sticky; cleared by a STATUS read), bit2 BUSY (FSM not IDLE). Upper bits are 0.
  - 6-7: read 0, writes ignored.
  - Writes to read-only registers are ignored.
- Period counter: runs only when CTRL.bit0=1 and PERIOD≠0. It counts 0..PERIOD-1; on reaching PERIOD-1 it raises a sample request and wraps to 0. Writing PERIOD or clearing enable zeroes the counter. PERIOD=1 requests a sample every cycle.
- Sample FSM:
  - IDLE: on a request (software, periodic, or pending) go to PULSE.
  - PULSE: `KNN_SAMPLE`=1 for exactly this cycle, then go to CAPTURE.
  - CAPTURE: the core has updated `KNN_VALUE` at the end of PULSE. At the end of CAPTURE latch `KNN_VALUE` into the snapshot. If NEW is already 1, set OVERRUN. Set NEW. Return to IDLE.
- Request merging:
  - Simultaneous software and periodic requests produce one pulse.
  - A request arriving in PULSE/CAPTURE sets a single pending flag. Further requests merge into it.
  - The pending request issues on the cycle after CAPTURE, so pulses are at minimum 3 cycles apart.
- Sampling with enable=0 is legal: the core returns its frozen value.

## Timing
- Bus handshake:
  - A request is accepted in a cycle where valid=1 and ready=0.
  - `ready`=1 exactly one cycle later, with `rdata` registered.
  - The cycle after `ready` cannot accept a new request; max throughput is one access per 2 cycles.
  - The master holds valid/address/wdata until ready.
- SAMPLE write accepted in cycle t: FSM enters PULSE at t+1 if IDLE, so `KNN_SAMPLE`=1 in the same cycle as `ready`. The snapshot and NEW update at the end of t+2.
- CTRL write accepted in cycle t: `KNN_ENABLE` changes at t+1.
- Read colliding with capture (acceptance cycle = CAPTURE): `rdata` returns the pre-capture snapshot.
- VALUE_HI read colliding with capture: NEW ends 1 and OVERRUN is not set by that capture.
- STATUS read colliding with an OVERRUN-setting capture: OVERRUN ends 1.
- Reset (rst=0 at a rising edge): all registers, snapshot, counter, and pending flag go to 0; FSM goes to IDLE. The outputs `rdata`, `ready`, `KNN_ENABLE`, `KNN_SAMPLE` are 0 from the next cycle. A reset mid-PULSE/CAPTURE aborts the capture.

## Test plan
- Reset: hold rst=0 for 5 cycles with valid=1 -> `ready`, `KNN_SAMPLE`, `KNN_ENABLE`, `rdata`=0; STATUS read after release = 0.
- Basic sample:
  - write CTRL=1, SAMPLE=1, then read VALUE_LO/HI -> exactly one 1-cycle `KNN_SAMPLE` pulse; snapshot equals `KNN_VALUE` at CAPTURE; STATUS=1 before HI read, 0 after.
  - Against `knn_core`: enable, sample, wait 1000 cycles, sample -> VALUE_LO=1003, VALUE_HI=0 under the core's existing timing.
- Periodic: CTRL=1, PERIOD=10 for 100 cycles -> 10 pulses spaced exactly 10 cycles apart. Without HI reads, OVERRUN=1 after the second capture; a STATUS read clears it to 0.
- Merging: a SAMPLE write landing in the same cycle as the period wrap -> one pulse. A SAMPLE write during CAPTURE -> a second pulse exactly 3 cycles after the first.
- Coherence: inject `KNN_VALUE` upper word changing from 0x00000000 to 0x00000001 between the LO and HI reads -> the HI read returns the snapshot word, not the live value.
- Reset mid-operation: assert rst in the PULSE cycle -> `KNN_SAMPLE`=0 next cycle, snapshot=0, NEW=0, no capture.
